// File: rtl/frac_pkg.sv
// Shared constants and stream-FSM state type for the fractional search front end.
package frac_pkg;

  localparam int ROWS     = 8;              // rows per block
  localparam int LINE_W   = 64;             // 8 pixels x 8 bits per row
  localparam int ORG_W    = 48;             // trimmed original row: pixels 1..6
  localparam int ORG_LO   = 8;              // lowest kept bit of an original row
  localparam int ORG_ROWS = ROWS - 2;       // original rows 1..6 are kept
  localparam int ROW_W    = $clog2(ROWS);
  localparam int MV_W     = 3;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_W1,
    S_W2
  } state_e;

endpackage

// File: rtl/feeder_bank.sv
// One ping-pong bank: 8 current rows plus original rows 1..6, written one row
// at a time and read combinationally by row index.
module feeder_bank
  import frac_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [LINE_W-1:0] wr_cur,
  input  logic [ORG_W-1:0]  wr_org,
  input  logic              wr_org_en,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [ROW_W-1:0]  rd_org_row,
  output logic [LINE_W-1:0] rd_cur,
  output logic [ORG_W-1:0]  rd_org
);

  logic [LINE_W-1:0] cur_mem [ROWS];
  logic [ORG_W-1:0]  org_mem [ORG_ROWS];

  // Original row k (1..6) lives at slot k-1.
  logic [ROW_W-1:0] wr_org_idx;
  logic [ROW_W-1:0] rd_org_idx;

  assign wr_org_idx = wr_row - 1'b1;
  assign rd_org_idx = rd_org_row - 1'b1;

  // Row write port.
  // NOTE: storage has no reset; a bank is only read after its full flag says all rows were written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      cur_mem[wr_row] <= wr_cur;
      if (wr_org_en) begin
        org_mem[wr_org_idx] <= wr_org;
      end
    end
  end

  assign rd_cur = cur_mem[rd_row];
  assign rd_org = (rd_org_idx < ROW_W'(ORG_ROWS)) ? org_mem[rd_org_idx] : '0;

endmodule

// File: rtl/frac_feeder.sv
// Ping-pong row buffer in front of frac_search: collects 8x8 current/original
// block pairs with arbitrary bubbles and replays each as a gap-free 8-beat
// burst with a one-row original lag, then captures the resulting motion vector.
module frac_feeder
  import frac_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINE_W-1:0] in_cur,
  input  logic [LINE_W-1:0] in_org,
  output logic              fs_ready,
  output logic [LINE_W-1:0] fs_cur_pix,
  output logic [ORG_W-1:0]  fs_org_pix,
  input  logic [MV_W-1:0]   fs_mvx,
  input  logic [MV_W-1:0]   fs_mvy,
  output logic              res_valid,
  output logic [MV_W-1:0]   res_mvx,
  output logic [MV_W-1:0]   res_mvy
);

  // ---------------- write side ----------------
  logic [1:0]       full;
  logic             wr_bank;
  logic [ROW_W-1:0] wr_row;
  logic             xfer;
  logic             wr_last;
  logic             org_en;

  // ---------------- stream side ----------------
  state_e           state, state_n;
  logic             rd_bank;
  logic [ROW_W-1:0] rd_row, rd_row_n;
  logic [ROW_W-1:0] rd_org_row;
  logic             clr_full;
  logic             beat_n;
  logic             res_take;
  logic [LINE_W-1:0] cur_n;
  logic [ORG_W-1:0]  org_n;

  logic [LINE_W-1:0] bank_cur [2];
  logic [ORG_W-1:0]  bank_org [2];

  // Original pixels 0 and 7 never reach frac_search.
  logic unused_org;
  assign unused_org = ^{in_org[LINE_W-1:ORG_LO+ORG_W], in_org[ORG_LO-1:0]};

  assign in_ready = !full[wr_bank];
  assign xfer     = in_valid && in_ready;
  assign wr_last  = xfer && (wr_row == LAST_ROW);
  assign org_en   = (wr_row != '0) && (wr_row != LAST_ROW);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    feeder_bank u_bank (
      .clk        (clk),
      .wr_en      (xfer && (wr_bank == 1'(b))),
      .wr_row     (wr_row),
      .wr_cur     (in_cur),
      .wr_org     (in_org[ORG_LO +: ORG_W]),
      .wr_org_en  (org_en),
      .rd_row     (rd_row_n),
      .rd_org_row (rd_org_row),
      .rd_cur     (bank_cur[b]),
      .rd_org     (bank_org[b])
    );
  end

  // Write pointer and full flags; a set and a clear of different banks in one cycle both apply.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_row  <= '0;
      wr_bank <= 1'b0;
      full    <= '0;
    end else begin
      if (xfer) begin
        if (wr_last) begin
          wr_row  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      if (clr_full) begin
        full[rd_bank] <= 1'b0;
      end
      if (wr_last) begin
        full[wr_bank] <= 1'b1;
      end
    end
  end

  // Next state, next read row and the values the output registers load.
  // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_n  = state;
    rd_row_n = rd_row;
    clr_full = 1'b0;
    beat_n   = 1'b0;
    res_take = 1'b0;
    case (state)
      S_IDLE: begin
        if (full[rd_bank]) begin
          state_n  = S_BURST;
          rd_row_n = '0;
          beat_n   = 1'b1;
        end
      end
      S_BURST: begin
        if (rd_row == LAST_ROW) begin
          state_n  = S_W1;
          clr_full = 1'b1;
        end else begin
          rd_row_n = rd_row + 1'b1;
          beat_n   = 1'b1;
        end
      end
      S_W1: begin
        state_n = S_W2;
      end
      S_W2: begin
        state_n  = S_IDLE;
        res_take = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Beat k carries original row k-1; beats 0 and 1 have no original row.
    rd_org_row = rd_row_n - 1'b1;
    cur_n      = beat_n ? bank_cur[rd_bank] : '0;
    org_n      = (beat_n && (rd_row_n >= ROW_W'(2))) ? bank_org[rd_bank] : '0;
  end

  // Stream FSM register plus registered frac_search and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rd_row     <= '0;
      rd_bank    <= 1'b0;
      fs_ready   <= 1'b0;
      fs_cur_pix <= '0;
      fs_org_pix <= '0;
      res_valid  <= 1'b0;
      res_mvx    <= '0;
      res_mvy    <= '0;
    end else begin
      state      <= state_n;
      rd_row     <= rd_row_n;
      fs_ready   <= beat_n;
      fs_cur_pix <= cur_n;
      fs_org_pix <= org_n;
      res_valid  <= res_take;
      if (clr_full) begin
        rd_bank <= ~rd_bank;
      end
      if (res_take) begin
        res_mvx <= fs_mvx;
        res_mvy <= fs_mvy;
      end
    end
  end

endmodule

// File: tb/tb_frac_feeder.sv
// Self-checking bench for frac_feeder: table of block rows, scoreboard of
// expected beats and results, stubbed frac_search result timing.
module tb_frac_feeder;
  import frac_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_cur = '0;
  logic [63:0] in_org = '0;
  logic        fs_ready;
  logic [63:0] fs_cur_pix;
  logic [47:0] fs_org_pix;
  logic [2:0]  fs_mvx = '0;
  logic [2:0]  fs_mvy = '0;
  logic        res_valid;
  logic [2:0]  res_mvx;
  logic [2:0]  res_mvy;

  always #5 clk = ~clk;

  frac_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cur     (in_cur),
    .in_org     (in_org),
    .fs_ready   (fs_ready),
    .fs_cur_pix (fs_cur_pix),
    .fs_org_pix (fs_org_pix),
    .fs_mvx     (fs_mvx),
    .fs_mvy     (fs_mvy),
    .res_valid  (res_valid),
    .res_mvx    (res_mvx),
    .res_mvy    (res_mvy)
  );

  typedef struct {
    logic [63:0] cur;
    logic [63:0] org;
    logic [63:0] exp_cur;
    logic [47:0] exp_org;
  } vec_t;

  typedef struct {
    logic [63:0] cur;
    logic [47:0] org;
  } beat_t;

  typedef struct {
    logic [2:0] mvx;
    logic [2:0] mvy;
  } res_t;

  vec_t  tbl [4][8];
  beat_t exp_beats [$];
  res_t  exp_res [$];
  int    starts [$];
  bit    rdy_hist [int];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int burst_beats = 0;
  int last_beat_cyc = -100;
  int stub_cnt = -1;
  int nres = 0;
  bit prev_res = 1'b0;
  beat_t mon_b;
  res_t  mon_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic has_ff(input logic [47:0] v);
    has_ff = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (v[j*8 +: 8] == 8'hFF) has_ff = 1'b1;
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: scoreboard compare, contiguity, idle zeros, result latency.
  always @(negedge clk) begin
    rdy_hist[cyc] = in_ready;
    if (reset) begin
      burst_beats = 0;
      prev_res    = 1'b0;
    end else begin
      if (fs_ready) begin
        if (burst_beats == 0) starts.push_back(cyc);
        if (exp_beats.size() == 0) begin
          check("unexpected_beat", 64'(fs_ready), 64'(0));
        end else begin
          mon_b = exp_beats.pop_front();
          check("beat_cur", fs_cur_pix, mon_b.cur);
          check("beat_org", 64'(fs_org_pix), 64'(mon_b.org));
        end
        check("org_no_ff", 64'(has_ff(fs_org_pix)), 64'(0));
        burst_beats++;
        if (burst_beats == 8) begin
          last_beat_cyc = cyc;
          burst_beats   = 0;
          stub_cnt      = 0;
        end
      end else begin
        if (burst_beats != 0) begin
          check("burst_contiguous", 64'(burst_beats), 64'(8));
          burst_beats = 0;
        end
        check("idle_cur_zero", fs_cur_pix, 64'(0));
        check("idle_org_zero", 64'(fs_org_pix), 64'(0));
      end
      if (res_valid) begin
        check("res_latency", 64'(cyc - last_beat_cyc), 64'(3));
        check("res_single_pulse", 64'(prev_res), 64'(0));
        if (exp_res.size() == 0) begin
          check("unexpected_res", 64'(res_valid), 64'(0));
        end else begin
          mon_r = exp_res.pop_front();
          check("res_mvx", 64'(res_mvx), 64'(mon_r.mvx));
          check("res_mvy", 64'(res_mvy), 64'(mon_r.mvy));
        end
      end
      prev_res = res_valid;
    end
  end

  // Stubbed frac_search: result is valid only in the second cycle after beat 7.
  always @(posedge clk) begin
    #1;
    if (stub_cnt >= 0) begin
      stub_cnt++;
      if (stub_cnt == 2) begin
        fs_mvx = 3'(3 + nres);
        fs_mvy = 3'(1 + 2 * nres);
        mon_r.mvx = fs_mvx;
        mon_r.mvy = fs_mvy;
        exp_res.push_back(mon_r);
      end else if (stub_cnt == 3) begin
        fs_mvx   = ~fs_mvx;
        fs_mvy   = ~fs_mvy;
        nres++;
        stub_cnt = -1;
      end
    end
  end

  task automatic send_row(input logic [63:0] cur, input logic [63:0] org, output int xfer_cyc);
    int waits;
    waits    = 0;
    in_valid = 1'b1;
    in_cur   = cur;
    in_org   = org;
    while (!in_ready && waits < 200) begin
      @(posedge clk);
      #1;
      waits++;
    end
    check("in_ready_wait", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    xfer_cyc = cyc;
  endtask

  task automatic send_block(input int b, input bit bubbles, output int e_cyc);
    int    t;
    beat_t nb;
    t = 0;
    for (int k = 0; k < 8; k++) begin
      send_row(tbl[b][k].cur, tbl[b][k].org, t);
      nb.cur = tbl[b][k].exp_cur;
      nb.org = tbl[b][k].exp_org;
      exp_beats.push_back(nb);
      if (bubbles) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    e_cyc = t;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_beats.size() != 0 || exp_res.size() != 0 || stub_cnt >= 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'(exp_beats.size() + exp_res.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int e0;
    int n;
    logic [63:0] o;

    // Block b, row k: cur bytes = b*16+k; org bytes 0 and 7 = FF, bytes 1..6 distinct.
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        o = '0;
        o[7:0]   = 8'hFF;
        o[63:56] = 8'hFF;
        for (int j = 1; j < 7; j++) o[j*8 +: 8] = 8'(b * 64 + k * 8 + j);
        tbl[b][k].cur     = {8{8'(b * 16 + k)}};
        tbl[b][k].org     = o;
        tbl[b][k].exp_cur = tbl[b][k].cur;
      end
      for (int k = 0; k < 8; k++) begin
        tbl[b][k].exp_org = (k >= 2) ? tbl[b][k-1].org[55:8] : 48'h0;
      end
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_fs_ready", 64'(fs_ready), 64'(0));
    check("rst_fs_cur", fs_cur_pix, 64'(0));
    check("rst_fs_org", 64'(fs_org_pix), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_mv", 64'({res_mvx, res_mvy}), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single block, no bubbles.
    starts.delete();
    send_block(0, 1'b0, e);
    in_valid = 1'b0;
    wait_drain("t1_drain");
    check("t1_nbursts", 64'(starts.size()), 64'(1));
    if (starts.size() >= 1) check("t1_start_lat", 64'(starts[0] - e), 64'(1));
    check("t1_res_mvx", 64'(res_mvx), 64'(3));
    check("t1_res_mvy", 64'(res_mvy), 64'(1));

    // Input bubbles.
    starts.delete();
    send_block(1, 1'b1, e);
    in_valid = 1'b0;
    wait_drain("t2_drain");
    check("t2_nbursts", 64'(starts.size()), 64'(1));
    if (starts.size() >= 1) check("t2_start_lat", 64'(starts[0] - e), 64'(1));

    // Continuous input, 4 blocks, with backpressure.
    starts.delete();
    rdy_hist.delete();
    send_block(0, 1'b0, e0);
    for (int b = 1; b < 4; b++) send_block(b, 1'b0, e);
    in_valid = 1'b0;
    wait_drain("t3_drain");
    check("t3_nbursts", 64'(starts.size()), 64'(4));
    if (starts.size() == 4) begin
      check("t3_start_lat", 64'(starts[0] - e0), 64'(1));
      for (int i = 0; i < 3; i++) check("t3_burst_spacing", 64'(starts[i+1] - starts[i]), 64'(11));
      check("t4_rdy_before_full", 64'(rdy_hist[starts[0] + 6]), 64'(1));
      check("t4_rdy_both_full", 64'(rdy_hist[starts[0] + 7]), 64'(0));
      check("t4_rdy_after_beat7", 64'(rdy_hist[starts[0] + 8]), 64'(1));
    end

    // Reset mid-burst at beat 4.
    starts.delete();
    send_block(2, 1'b0, e);
    in_valid = 1'b0;
    n = 0;
    while (!(fs_ready && burst_beats == 4) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_reach_beat4", 64'(fs_ready && burst_beats == 4), 64'(1));
    reset = 1'b1;
    #1;
    check("t5_rst_fs_ready", 64'(fs_ready), 64'(0));
    check("t5_rst_fs_cur", fs_cur_pix, 64'(0));
    check("t5_rst_fs_org", 64'(fs_org_pix), 64'(0));
    check("t5_rst_res_valid", 64'(res_valid), 64'(0));
    check("t5_rst_in_ready", 64'(in_ready), 64'(1));
    exp_beats.delete();
    exp_res.delete();
    stub_cnt = -1;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    starts.delete();
    repeat (15) @(posedge clk);
    #1;
    check("t5_no_stale_burst", 64'(starts.size()), 64'(0));
    send_block(3, 1'b0, e);
    in_valid = 1'b0;
    wait_drain("t5_drain");
    check("t5_nbursts", 64'(starts.size()), 64'(1));
    if (starts.size() >= 1) check("t5_start_lat", 64'(starts[0] - e), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
